// File: rtl/jericalla_pkg.sv
// Shared constants, state type and instruction encoder for the jericalla sequencer.
// Field layout of the 17-bit instruction word: waddr | op | r1 | r2 | we.
package jericalla_pkg;

    localparam int INSTR_W  = 17;
    localparam int WADDR_HI = 16;
    localparam int WADDR_LO = 13;
    localparam int OP_HI    = 12;
    localparam int OP_LO    = 9;
    localparam int R1_HI    = 8;
    localparam int R1_LO    = 5;
    localparam int R2_HI    = 4;
    localparam int R2_LO    = 1;
    localparam int WE_BIT   = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMITIR = 2'd1,
        FIN    = 2'd2
    } estado_e;

    function automatic logic [INSTR_W-1:0] make_instr(
        input logic [3:0] waddr,
        input logic [3:0] op,
        input logic [3:0] r1,
        input logic [3:0] r2,
        input logic       we
    );
        logic [INSTR_W-1:0] w;
        w                    = '0;
        w[WADDR_HI:WADDR_LO] = waddr;
        w[OP_HI:OP_LO]       = op;
        w[R1_HI:R1_LO]       = r1;
        w[R2_HI:R2_LO]       = r2;
        w[WE_BIT]            = we;
        return w;
    endfunction

endpackage

// File: rtl/jericalla_secuenciador_if.sv
// Control/status bundle between the test logic (master) and the sequencer (slave).
interface jericalla_secuenciador_if #(
    parameter int ADDR_W = 4
);
    import jericalla_pkg::*;

    logic               cargar;
    logic [ADDR_W-1:0]  dirCarga;
    logic [INSTR_W-1:0] instrCarga;
    logic               inicio;
    logic [ADDR_W:0]    longitud;
    logic               paraEnCero;
    logic               zf_in;
    logic [INSTR_W-1:0] instruccion;
    logic               valido;
    logic               ocupado;
    logic               hecho;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W:0]    cuentaZ;
    logic               paroZ;

    modport master (
        output cargar, dirCarga, instrCarga, inicio, longitud, paraEnCero, zf_in,
        input  instruccion, valido, ocupado, hecho, pc, cuentaZ, paroZ
    );

    modport slave (
        input  cargar, dirCarga, instrCarga, inicio, longitud, paraEnCero, zf_in,
        output instruccion, valido, ocupado, hecho, pc, cuentaZ, paroZ
    );

endinterface

// File: rtl/jericalla_mem_prog.sv
// Program store: synchronous write, asynchronous read, deliberately not reset.
module jericalla_mem_prog #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 17
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jericalla_secuenciador.sv
// Instruction issuer: steps through the loaded program, holds each word HOLD_CYC+1
// cycles, counts zero-flag hits on the last hold cycle and optionally stops on zero.
module jericalla_secuenciador
    import jericalla_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int HOLD_CYC   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    jericalla_secuenciador_if.slave    sec_if
);

    localparam int              HOLD_W    = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC);
    localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W + 1)'(PROG_DEPTH);
    localparam logic [ADDR_W:0]   UNO       = (ADDR_W + 1)'(1);

    estado_e            estado_q, estado_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W:0]    cuenta_q, cuenta_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic               paro_q, paro_d;
    logic               stop_q, stop_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    logic [INSTR_W-1:0] palabra;
    logic [INSTR_W-1:0] instr_c;
    logic               valido_c, ocupado_c, hecho_c;
    logic [ADDR_W:0]    len_sat;
    logic               ultimo;
    logic               mem_we;

    assign mem_we  = (estado_q == IDLE) && sec_if.cargar;
    assign len_sat = (sec_if.longitud > LEN_MAX) ? LEN_MAX : sec_if.longitud;
    assign ultimo  = ({1'b0, pc_q} == (len_q - UNO));

    jericalla_mem_prog #(
        .DEPTH  (PROG_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (INSTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (sec_if.dirCarga),
        .wdata_i (sec_if.instrCarga),
        .raddr_i (pc_q),
        .rdata_o (palabra)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= IDLE;
            pc_q     <= '0;
            cuenta_q <= '0;
            len_q    <= '0;
            paro_q   <= 1'b0;
            stop_q   <= 1'b0;
            hold_q   <= '0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            cuenta_q <= cuenta_d;
            len_q    <= len_d;
            paro_q   <= paro_d;
            stop_q   <= stop_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        pc_d      = pc_q;
        cuenta_d  = cuenta_q;
        len_d     = len_q;
        paro_d    = paro_q;
        stop_d    = stop_q;
        hold_d    = hold_q;
        instr_c   = '0;
        valido_c  = 1'b0;
        ocupado_c = 1'b0;
        hecho_c   = 1'b0;
        case (estado_q)
            IDLE: begin
                if (sec_if.inicio) begin
                    pc_d     = '0;
                    cuenta_d = '0;
                    paro_d   = 1'b0;
                    len_d    = len_sat;
                    stop_d   = sec_if.paraEnCero;
                    hold_d   = HOLD_INIT;
                    estado_d = (len_sat == '0) ? FIN : EMITIR;
                end
            end
            EMITIR: begin
                instr_c   = palabra;
                valido_c  = 1'b1;
                ocupado_c = 1'b1;
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
                    // last hold cycle: the only point where zf is looked at
                    hold_d = HOLD_INIT;
                    if (sec_if.zf_in) begin
                        cuenta_d = cuenta_q + UNO;
                    end
                    if (stop_q && sec_if.zf_in) begin
                        paro_d   = 1'b1;
                        estado_d = FIN;
                    end else if (ultimo) begin
                        estado_d = FIN;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            FIN: begin
                hecho_c   = 1'b1;
                ocupado_c = 1'b1;
                estado_d  = IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

    assign sec_if.instruccion = instr_c;
    assign sec_if.valido      = valido_c;
    assign sec_if.ocupado     = ocupado_c;
    assign sec_if.hecho       = hecho_c;
    assign sec_if.pc          = pc_q;
    assign sec_if.cuentaZ     = cuenta_q;
    assign sec_if.paroZ       = paro_q;

endmodule

// File: tb/tb_jericalla_secuenciador.sv
// Directed bench for jericalla_secuenciador: a vector table for the basic runs,
// hand sequences for early stop, length limits, hold cycles and reset mid-run.
module tb_jericalla_secuenciador;
    import jericalla_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jericalla_secuenciador_if #(.ADDR_W(4)) if0 ();
    jericalla_secuenciador_if #(.ADDR_W(4)) if2 ();

    jericalla_secuenciador #(.PROG_DEPTH(16), .ADDR_W(4), .HOLD_CYC(0)) u0 (
        .clk    (clk),
        .rst    (rst),
        .sec_if (if0)
    );

    jericalla_secuenciador #(.PROG_DEPTH(16), .ADDR_W(4), .HOLD_CYC(2)) u2 (
        .clk    (clk),
        .rst    (rst),
        .sec_if (if2)
    );

    typedef struct packed {
        logic        cargar;
        logic [3:0]  dir;
        logic [16:0] dato;
        logic        inicio;
        logic [4:0]  lon;
        logic        zf;
        logic [16:0] e_instr;
        logic        e_val;
        logic        e_ocu;
        logic        e_hec;
        logic [3:0]  e_pc;
        logic [4:0]  e_cz;
        logic        e_paro;
    } vec_t;

    vec_t        tabla [16];
    logic [16:0] prog  [16];
    int          n_vec = 0;
    int          n_err = 0;
    int          iss;
    logic        to;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [29:0] obs0();
        return {if0.instruccion, if0.valido, if0.ocupado, if0.hecho, if0.pc, if0.cuentaZ, if0.paroZ};
    endfunction

    function automatic logic [29:0] obs2();
        return {if2.instruccion, if2.valido, if2.ocupado, if2.hecho, if2.pc, if2.cuentaZ, if2.paroZ};
    endfunction

    // Runs u0; zmask[k] drives zf on the last cycle of issue k; meddle holds cargar during the run.
    task automatic run0(input logic [4:0] lon, input logic pez, input logic [15:0] zmask,
                        input logic meddle, output int n_iss, output logic t_out);
        if0.inicio     = 1'b1;
        if0.longitud   = lon;
        if0.paraEnCero = pez;
        tick();
        if0.inicio     = 1'b0;
        if0.cargar     = 1'b0;
        if0.paraEnCero = ~pez;
        if0.longitud   = 5'd1;
        n_iss = 0;
        t_out = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (if0.hecho === 1'b1) begin
                t_out = 1'b0;
                break;
            end
            if (if0.valido === 1'b1) begin
                chk("run_instr", 32'(if0.instruccion), 32'(prog[n_iss[3:0]]));
                if0.zf_in = zmask[n_iss[3:0]];
                n_iss++;
            end else begin
                if0.zf_in = 1'b0;
            end
            if (meddle) begin
                if0.cargar     = 1'b1;
                if0.dirCarga   = c[3:0];
                if0.instrCarga = 17'h1FFFF;
            end
            tick();
        end
        if0.zf_in      = 1'b0;
        if0.cargar     = 1'b0;
        if0.paraEnCero = 1'b0;
        chk("run_timeout", 32'(t_out), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tabla[0]  = '{1'b1, 4'd0, 17'h06429, 1'b0, 5'd0, 1'b0, 17'h00000, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0};
        tabla[1]  = '{1'b1, 4'd1, 17'h00000, 1'b0, 5'd0, 1'b0, 17'h00000, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0};
        tabla[2]  = '{1'b1, 4'd2, 17'h1ABCD, 1'b0, 5'd0, 1'b0, 17'h00000, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0};
        tabla[3]  = '{1'b1, 4'd3, 17'h0F0F1, 1'b0, 5'd0, 1'b0, 17'h00000, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0};
        tabla[4]  = '{1'b0, 4'd0, 17'h00000, 1'b1, 5'd2, 1'b0, 17'h06429, 1'b1, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0};
        tabla[5]  = '{1'b0, 4'd0, 17'h00000, 1'b0, 5'd0, 1'b0, 17'h00000, 1'b1, 1'b1, 1'b0, 4'd1, 5'd0, 1'b0};
        tabla[6]  = '{1'b0, 4'd0, 17'h00000, 1'b0, 5'd0, 1'b0, 17'h00000, 1'b0, 1'b1, 1'b1, 4'd1, 5'd0, 1'b0};
        tabla[7]  = '{1'b0, 4'd0, 17'h00000, 1'b0, 5'd0, 1'b0, 17'h00000, 1'b0, 1'b0, 1'b0, 4'd1, 5'd0, 1'b0};
        tabla[8]  = '{1'b0, 4'd0, 17'h00000, 1'b1, 5'd4, 1'b0, 17'h06429, 1'b1, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0};
        tabla[9]  = '{1'b0, 4'd0, 17'h00000, 1'b0, 5'd0, 1'b1, 17'h00000, 1'b1, 1'b1, 1'b0, 4'd1, 5'd1, 1'b0};
        tabla[10] = '{1'b0, 4'd0, 17'h00000, 1'b1, 5'd1, 1'b0, 17'h1ABCD, 1'b1, 1'b1, 1'b0, 4'd2, 5'd1, 1'b0};
        tabla[11] = '{1'b0, 4'd0, 17'h00000, 1'b0, 5'd0, 1'b1, 17'h0F0F1, 1'b1, 1'b1, 1'b0, 4'd3, 5'd2, 1'b0};
        tabla[12] = '{1'b0, 4'd0, 17'h00000, 1'b0, 5'd0, 1'b0, 17'h00000, 1'b0, 1'b1, 1'b1, 4'd3, 5'd2, 1'b0};
        tabla[13] = '{1'b0, 4'd0, 17'h00000, 1'b0, 5'd0, 1'b0, 17'h00000, 1'b0, 1'b0, 1'b0, 4'd3, 5'd2, 1'b0};
        tabla[14] = '{1'b0, 4'd0, 17'h00000, 1'b1, 5'd0, 1'b0, 17'h00000, 1'b0, 1'b1, 1'b1, 4'd0, 5'd0, 1'b0};
        tabla[15] = '{1'b0, 4'd0, 17'h00000, 1'b0, 5'd0, 1'b0, 17'h00000, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0};

        prog[0] = 17'h06429;
        prog[1] = 17'h00000;
        prog[2] = 17'h1ABCD;
        prog[3] = 17'h0F0F1;
        for (int i = 4; i < 16; i++) begin
            prog[i] = make_instr(4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3), i[0]);
        end

        {if0.cargar, if0.dirCarga, if0.instrCarga, if0.inicio, if0.longitud, if0.paraEnCero, if0.zf_in} = '0;
        {if2.cargar, if2.dirCarga, if2.instrCarga, if2.inicio, if2.longitud, if2.paraEnCero, if2.zf_in} = '0;

        tick();
        tick();
        chk("reset_u0", 32'(obs0()), 32'd0);
        chk("reset_u2", 32'(obs2()), 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 16; v++) begin
            if0.cargar     = tabla[v].cargar;
            if0.dirCarga   = tabla[v].dir;
            if0.instrCarga = tabla[v].dato;
            if0.inicio     = tabla[v].inicio;
            if0.longitud   = tabla[v].lon;
            if0.zf_in      = tabla[v].zf;
            tick();
            chk($sformatf("vec%0d", v), 32'(obs0()),
                32'({tabla[v].e_instr, tabla[v].e_val, tabla[v].e_ocu, tabla[v].e_hec,
                     tabla[v].e_pc, tabla[v].e_cz, tabla[v].e_paro}));
        end
        {if0.cargar, if0.inicio, if0.longitud, if0.zf_in} = '0;

        for (int i = 4; i < 16; i++) begin
            if0.cargar     = 1'b1;
            if0.dirCarga   = 4'(i);
            if0.instrCarga = prog[i];
            tick();
        end
        if0.cargar = 1'b0;

        // early stop on zero at issue 3
        run0(5'd8, 1'b1, 16'h0008, 1'b0, iss, to);
        chk("stop_issues", 32'(iss), 32'd4);
        chk("stop_hecho", 32'(if0.hecho), 32'd1);
        chk("stop_pc", 32'(if0.pc), 32'd3);
        chk("stop_paroZ", 32'(if0.paroZ), 32'd1);
        chk("stop_cuentaZ", 32'(if0.cuentaZ), 32'd1);
        tick();
        chk("stop_idle", 32'({if0.ocupado, if0.paroZ, if0.pc}), 32'({1'b0, 1'b1, 4'd3}));

        run0(5'd16, 1'b0, 16'h8001, 1'b0, iss, to);
        chk("len16_issues", 32'(iss), 32'd16);
        chk("len16_pc", 32'(if0.pc), 32'd15);
        chk("len16_cuentaZ", 32'(if0.cuentaZ), 32'd2);
        chk("len16_paroZ", 32'(if0.paroZ), 32'd0);
        tick();

        run0(5'd31, 1'b0, 16'h0000, 1'b0, iss, to);
        chk("clamp_issues", 32'(iss), 32'd16);
        chk("clamp_pc", 32'(if0.pc), 32'd15);
        tick();

        run0(5'd2, 1'b0, 16'h0000, 1'b1, iss, to);
        chk("meddle_issues", 32'(iss), 32'd2);
        tick();
        run0(5'd3, 1'b0, 16'h0000, 1'b0, iss, to);
        chk("rerun_issues", 32'(iss), 32'd3);
        tick();

        // HOLD_CYC=2: zf on hold cycles 1-2 of issue 0 must be ignored
        if2.cargar     = 1'b1;
        if2.dirCarga   = 4'd0;
        if2.instrCarga = 17'h12345;
        tick();
        if2.dirCarga   = 4'd1;
        if2.instrCarga = 17'h0ABCD;
        tick();
        if2.cargar   = 1'b0;
        if2.inicio   = 1'b1;
        if2.longitud = 5'd2;
        tick();
        if2.inicio = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("hold_instr", 32'(if2.instruccion), (c < 3) ? 32'h12345 : 32'h0ABCD);
            chk("hold_valido", 32'(if2.valido), 32'd1);
            if (c == 3) chk("hold_zf_ignored", 32'(if2.cuentaZ), 32'd0);
            if2.zf_in = (c == 0 || c == 1 || c == 5);
            tick();
        end
        if2.zf_in = 1'b0;
        chk("hold_end", 32'({if2.hecho, if2.pc, if2.cuentaZ}), 32'({1'b1, 4'd1, 5'd1}));
        tick();
        chk("hold_idle", 32'(obs2()), 32'({17'h0, 1'b0, 1'b0, 1'b0, 4'd1, 5'd1, 1'b0}));

        // asynchronous reset in the middle of EMITIR
        if0.inicio   = 1'b1;
        if0.longitud = 5'd4;
        tick();
        if0.inicio = 1'b0;
        tick();
        chk("pre_reset_valido", 32'(if0.valido), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", 32'({if0.instruccion, if0.valido, if0.ocupado}), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("reset_no_hecho", 32'({if0.hecho, if0.ocupado}), 32'd0);
        end
        #2 rst = 1'b0;
        tick();
        chk("post_reset", 32'(obs0()), 32'd0);
        run0(5'd4, 1'b0, 16'h0000, 1'b0, iss, to);
        chk("post_reset_issues", 32'(iss), 32'd4);
        tick();

        // write and start on the same edge: first issue sees the new word
        if0.cargar     = 1'b1;
        if0.dirCarga   = 4'd0;
        if0.instrCarga = 17'h1C0DE;
        prog[0]        = 17'h1C0DE;
        run0(5'd1, 1'b0, 16'h0000, 1'b0, iss, to);
        chk("same_edge_issues", 32'(iss), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
